// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: op codes and op-decoding helpers for the iterative multiply/divide unit
package muldiv_unit_pkg;
  localparam logic [1:0] MULDIV_MULT  = 2'b00;
  localparam logic [1:0] MULDIV_MULTU = 2'b01;
  localparam logic [1:0] MULDIV_DIV   = 2'b10;
  localparam logic [1:0] MULDIV_DIVU  = 2'b11;
  function automatic logic op_signed(input logic [1:0] op);
    return !op[0];
  endfunction
  function automatic logic op_div(input logic [1:0] op);
    return op[1];
  endfunction
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: pipeline <-> multiply/divide unit handshake and HI/LO write port
// master (pipeline): drives start, op, rs_data, rt_data, cancel; sees busy, hilo_wr_en, hilo_wr_data
// slave (muldiv_unit): the reverse
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   rs_data;
  logic [WIDTH-1:0]   rt_data;
  logic               cancel;
  logic               busy;
  logic               hilo_wr_en;
  logic [2*WIDTH-1:0] hilo_wr_data;
  modport master(output start, op, rs_data, rt_data, cancel, input busy, hilo_wr_en, hilo_wr_data);
  modport slave(input start, op, rs_data, rt_data, cancel, output busy, hilo_wr_en, hilo_wr_data);
endinterface

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shift-add multiplier / restoring divider registers with final sign correction
// load: capture opa (multiplier or dividend) and opm (multiplicand or divisor)
// step: one bit of multiply or divide; fix: apply neg_q/neg_r correction; res: {HI,LO}
module muldiv_datapath #(parameter int WIDTH = 32) (
  input  logic               clk_cpu,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  logic               is_div,
  input  logic               neg_q,
  input  logic               neg_r,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opm,
  output logic [2*WIDTH-1:0] res
);
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   m;
  logic [WIDTH:0]     rem;
  logic [WIDTH:0]     sum;
  logic [WIDTH+1:0]   sh;
  logic [WIDTH+1:0]   trial;
  // multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
  // divide: acc[WIDTH-1:0] shifts dividend bits out of the top and quotient bits in at the bottom
  assign sh = {rem, acc[WIDTH-1]};
  assign trial = sh - {2'b0, m};
  assign res = acc;
  always_ff @(posedge clk_cpu or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      m <= '0;
      rem <= '0;
    end else if (load) begin
      acc <= {{WIDTH{1'b0}}, opa};
      m <= opm;
      rem <= '0;
    end else if (step && is_div) begin
      rem <= trial[WIDTH+1] ? sh[WIDTH:0] : trial[WIDTH:0];
      acc <= {{WIDTH{1'b0}}, acc[WIDTH-2:0], !trial[WIDTH+1]};
    end else if (step) begin
      acc <= {sum, acc[WIDTH-1:1]};
    end else if (fix) begin
      acc <= is_div ? {neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0], neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]}
                    : (neg_q ? -acc : acc);
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS MULT/MULTU/DIV/DIVU engine writing {HI,LO} with a one-cycle strobe
// clk_cpu/reset_n: clock and async active-low reset; bus: muldiv_unit_if slave port
module muldiv_unit import muldiv_unit_pkg::*; #(parameter int WIDTH = 32) (
  input logic          clk_cpu,
  input logic          reset_n,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_q, neg_r;
  logic               load, step, fix, wr;
  logic               sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] res;
  assign sa = op_signed(bus.op) & bus.rs_data[WIDTH-1];
  assign sb = op_signed(bus.op) & bus.rt_data[WIDTH-1];
  assign abs_a = sa ? -bus.rs_data : bus.rs_data;
  assign abs_b = sb ? -bus.rt_data : bus.rt_data;
  // busy covers the strobe cycle too, so a start there is ignored
  assign bus.busy = state != IDLE || bus.hilo_wr_en;
  always_comb begin
    load = state == IDLE && bus.start && !bus.cancel && !bus.busy;
    step = state == CALC;
    fix = state == FIX;
    wr = state == DONE && !bus.cancel;
    state_nx = (bus.cancel && state != IDLE) ? IDLE :
               load ? CALC :
               (step && cnt == CW'(WIDTH-1)) ? FIX :
               fix ? DONE :
               state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk_cpu or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk_cpu or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      bus.hilo_wr_en <= 1'b0;
      bus.hilo_wr_data <= '0;
    end else begin
      cnt <= (step && !bus.cancel) ? cnt + 1'b1 : '0;
      if (load) begin
        is_div <= op_div(bus.op);
        // divide by zero keeps the all-ones quotient; remainder sign fix restores raw rs
        neg_q <= (sa ^ sb) & |bus.rt_data;
        neg_r <= sa;
      end
      bus.hilo_wr_en <= wr;
      if (wr) bus.hilo_wr_data <= res;
    end
  end
  muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk_cpu(clk_cpu),
    .reset_n(reset_n),
    .load(load),
    .step(step),
    .fix(fix),
    .is_div(is_div),
    .neg_q(neg_q),
    .neg_r(neg_r),
    .opa(op_div(bus.op) ? abs_a : abs_b),
    .opm(op_div(bus.op) ? abs_b : abs_a),
    .res(res)
  );
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors, corner sequences and randomized ops against an arithmetic model
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;
  logic clk_cpu = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [63:0] last_data = '0;
  always #5 clk_cpu = ~clk_cpu;
  muldiv_unit_if bus();
  muldiv_unit dut(.clk_cpu(clk_cpu), .reset_n(reset_n), .bus(bus));
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    string       nm;
  } vec_t;
  vec_t vt[9];
  task automatic tick();
    @(posedge clk_cpu);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (o == MULDIV_MULT) return 64'(sa * sb);
    if (o == MULDIV_MULTU) return ua * ub;
    if (b == 0) return {a, 32'hffffffff};
    if (o == MULDIV_DIV) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {32'(ua % ub), 32'(ua / ub)};
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hffffffff;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      4: return 32'd0 - 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction
  // cancel_at/dup_at: cycle after E0 (0 = cycle right after the accepting edge) to pulse cancel/start
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int cancel_at, input int dup_at, input string nm);
    int seen, lat, last;
    bus.op = o;
    bus.rs_data = a;
    bus.rt_data = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.op = 2'($urandom);
    bus.rs_data = $urandom;
    bus.rt_data = $urandom;
    chk({nm, " busy after start"}, 64'(bus.busy), 64'd1);
    seen = 0;
    lat = -1;
    last = cancel_at >= 0 ? 40 : 35;
    for (int k = 1; k <= last; k++) begin
      if (k - 1 == dup_at) begin
        bus.start = 1'b1;
        bus.op = 2'($urandom);
        bus.rs_data = $urandom;
        bus.rt_data = $urandom;
      end
      if (k - 1 == cancel_at) bus.cancel = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.cancel = 1'b0;
      if (bus.hilo_wr_en) begin
        seen++;
        if (lat < 0) lat = k;
      end
      if (cancel_at >= 0 && k == cancel_at + 1) chk({nm, " busy after cancel"}, 64'(bus.busy), 64'd0);
      if (cancel_at < 0 && k == 34) chk({nm, " busy in strobe cycle"}, 64'(bus.busy), 64'd1);
    end
    if (cancel_at >= 0) begin
      chk({nm, " strobes after cancel"}, 64'(seen), 64'd0);
      chk({nm, " data held"}, bus.hilo_wr_data, last_data);
    end else begin
      chk({nm, " latency"}, 64'(lat), 64'd34);
      chk({nm, " pulses"}, 64'(seen), 64'd1);
      chk({nm, " data"}, bus.hilo_wr_data, exp);
      chk({nm, " busy released"}, 64'(bus.busy), 64'd0);
      last_data = exp;
    end
  endtask
  initial begin
    int seen;
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    bus.op = '0;
    bus.rs_data = '0;
    bus.rt_data = '0;
    vt[0] = '{MULDIV_MULTU, 32'hffffffff, 32'hffffffff, 64'hfffffffe_00000001, "multu max"};
    vt[1] = '{MULDIV_MULT,  32'hfffffffd, 32'h00000007, 64'hffffffff_ffffffeb, "mult -3*7"};
    vt[2] = '{MULDIV_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000, "mult min*min"};
    vt[3] = '{MULDIV_DIV,   32'hfffffff9, 32'h00000002, 64'hffffffff_fffffffd, "div -7/2"};
    vt[4] = '{MULDIV_DIVU,  32'h00000007, 32'h00000002, 64'h00000001_00000003, "divu 7/2"};
    vt[5] = '{MULDIV_DIVU,  32'h00000007, 32'h00000000, 64'h00000007_ffffffff, "divu 7/0"};
    vt[6] = '{MULDIV_DIV,   32'h80000000, 32'hffffffff, 64'h00000000_80000000, "div min/-1"};
    vt[7] = '{MULDIV_DIV,   32'hfffffff9, 32'h00000000, 64'hfffffff9_ffffffff, "div -7/0"};
    vt[8] = '{MULDIV_DIV,   32'h00000064, 32'hfffffff9, 64'h00000002_fffffff2, "div 100/-7"};
    repeat (2) tick();
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset wr_en", 64'(bus.hilo_wr_en), 64'd0);
    chk("reset data", bus.hilo_wr_data, 64'd0);
    reset_n = 1'b1;
    tick();
    foreach (vt[i]) run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, -1, -1, vt[i].nm);
    run_op(MULDIV_MULTU, 32'd1234, 32'd5678, 64'd7006652, -1, 5, "start while busy");
    run_op(MULDIV_DIVU, 32'd100, 32'd3, 64'h00000001_00000021, -1, 34, "start in strobe cycle");
    run_op(MULDIV_MULT, 32'd9, 32'd9, 64'd81, 10, -1, "cancel at 10");
    run_op(MULDIV_MULTU, 32'd6, 32'd7, 64'd42, -1, -1, "after cancel");
    run_op(MULDIV_DIV, 32'd50, 32'd7, 64'h0, 33, -1, "cancel in done");
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    chk("idle cancel data", bus.hilo_wr_data, last_data);
    bus.start = 1'b1;
    bus.cancel = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    chk("start+cancel dropped", 64'(bus.busy), 64'd0);
    repeat (5) tick();
    chk("start+cancel still idle", 64'(bus.busy), 64'd0);
    bus.op = MULDIV_MULTU;
    bus.rs_data = 32'd3;
    bus.rt_data = 32'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (20) tick();
    reset_n = 1'b0;
    #1;
    chk("async reset busy", 64'(bus.busy), 64'd0);
    chk("async reset wr_en", 64'(bus.hilo_wr_en), 64'd0);
    chk("async reset data", bus.hilo_wr_data, 64'd0);
    last_data = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.hilo_wr_en) seen++;
    end
    chk("no strobe after reset", 64'(seen), 64'd0);
    for (int n = 0; n < 1500; n++) begin
      logic [1:0] o;
      logic [31:0] a, b;
      int r, ca, da;
      o = 2'($urandom);
      a = pick();
      b = pick();
      r = $urandom_range(0, 9);
      ca = r == 0 ? $urandom_range(0, 33) : -1;
      da = (r == 1 || r == 2) ? $urandom_range(0, 34) : -1;
      run_op(o, a, b, model(o, a, b), ca, da, "random");
      repeat ($urandom_range(0, 2)) tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
